// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_pkg
//  Description : Shared definitions for the minutes:seconds countdown timer.
//                Holds the controller state encoding, the BCD digit widths
//                and the per-digit upper limits.
//  Revision    : 1.0  initial release
// ============================================================================
package countdown_timer_pkg;

    // Digit widths: tens digit 0..5, units digit 0..9
    localparam int TENS_W  = 3;
    localparam int UNITS_W = 4;

    // Largest legal value of each digit
    localparam logic [TENS_W-1:0]  TENS_MAX  = 3'd5;
    localparam logic [UNITS_W-1:0] UNITS_MAX = 4'd9;

    // Width of the alarm duration counter (ALARM_SEC is at most 15)
    localparam int ACNT_W = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALM   = 2'd3
    } state_t;

endpackage : countdown_timer_pkg
`default_nettype wire

// File: rtl/countdown_timer_sexa_updown.sv
`default_nettype none
// ============================================================================
//  Module      : sexa_updown
//  Description : Two-digit BCD counter over 00..59 that can step up or down.
//                Incrementing wraps 59->00 silently; decrementing wraps
//                00->59 and reports a borrow so a higher stage can follow.
//  Ports       : CLK   - clock, rising edge
//                RST   - asynchronous active-low reset, clears to 00
//                clr   - synchronous clear to 00 (highest priority)
//                inc   - step up by one
//                dec   - step down by one (local request)
//                bin   - borrow in from a lower stage, also steps down
//                H, L  - tens / units BCD digits
//                bout  - borrow out: a down-step is requested while at 00
//                zero  - value is 00
//  Revision    : 1.0  initial release
// ============================================================================
module sexa_updown
    import countdown_timer_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               clr,
    input  logic               inc,
    input  logic               dec,
    input  logic               bin,
    output logic [TENS_W-1:0]  H,
    output logic [UNITS_W-1:0] L,
    output logic               bout,
    output logic               zero
);

    logic [TENS_W-1:0]  r_h;
    logic [UNITS_W-1:0] r_l;
    logic [TENS_W-1:0]  w_h_nxt;
    logic [UNITS_W-1:0] w_l_nxt;
    logic               w_down;

    // A local decrement and an incoming borrow both mean "one less"
    assign w_down = dec | bin;
    assign zero   = (r_h == '0) && (r_l == '0);
    assign bout   = w_down & zero;

    always_comb begin
        w_h_nxt = r_h;
        w_l_nxt = r_l;
        if (clr) begin
            w_h_nxt = '0;
            w_l_nxt = '0;
        end else if (inc) begin
            if (r_l == UNITS_MAX) begin
                w_l_nxt = '0;
                w_h_nxt = (r_h == TENS_MAX) ? '0 : r_h + 1'b1;
            end else begin
                w_l_nxt = r_l + 1'b1;
            end
        end else if (w_down) begin
            if (r_l == '0) begin
                w_l_nxt = UNITS_MAX;
                w_h_nxt = (r_h == '0) ? TENS_MAX : r_h - 1'b1;
            end else begin
                w_l_nxt = r_l - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_h <= '0;
            r_l <= '0;
        end else begin
            r_h <= w_h_nxt;
            r_l <= w_l_nxt;
        end
    end

    assign H = r_h;
    assign L = r_l;

endmodule : sexa_updown
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : MM:SS countdown timer. Time is set with MINUP/SECUP in
//                IDLE, START runs / pauses the countdown (one step per 1 Hz
//                EN), and reaching 00:00 raises ALARM for ALARM_SEC enables
//                or until acknowledged with START/CLR.
//  Ports       : CLK, RST (async active-low), EN (1 Hz enable), START, CLR,
//                MINUP, SECUP (one-cycle pulses); MH/ML/SH/SL BCD digits,
//                RUNNING and ALARM status flags.
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int ALARM_SEC = 10
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               START,
    input  logic               CLR,
    input  logic               MINUP,
    input  logic               SECUP,
    output logic [TENS_W-1:0]  MH,
    output logic [UNITS_W-1:0] ML,
    output logic [TENS_W-1:0]  SH,
    output logic [UNITS_W-1:0] SL,
    output logic               RUNNING,
    output logic               ALARM
);

    localparam logic [ACNT_W-1:0] c_alarm_last = ACNT_W'(ALARM_SEC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACNT_W-1:0]   r_acnt;
    logic [ACNT_W-1:0]   w_acnt_nxt;

    logic                w_clr;
    logic                w_inc_m;
    logic                w_inc_s;
    logic                w_dec_s;
    logic                w_sec_bout;
    logic                w_sec_zero;
    logic                w_min_bout;
    logic                w_min_zero;
    logic                w_all_zero;
    logic                w_at_one;

    assign w_all_zero = w_min_zero & w_sec_zero;
    // 00:01 -- the next decrement lands on zero and must enter the alarm
    assign w_at_one   = w_min_zero && (SH == '0) && (SL == 4'd1);

    // ------------------------------------------------------------------
    // Next-state / control decode. Priority: CLR > START > MINUP/SECUP > EN
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acnt_nxt  = r_acnt;
        w_clr       = 1'b0;
        w_inc_m     = 1'b0;
        w_inc_s     = 1'b0;
        w_dec_s     = 1'b0;

        if (CLR) begin
            w_state_nxt = ST_IDLE;
            w_acnt_nxt  = '0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        if (!w_all_zero) begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_inc_m = MINUP;
                        w_inc_s = SECUP;
                    end
                end
                ST_RUN: begin
                    if (START) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (EN) begin
                        // Zero in RUN is unreachable; guard so the digits
                        // can never wrap to 59:59 if it ever happened.
                        if (w_all_zero) begin
                            w_state_nxt = ST_ALM;
                        end else begin
                            w_dec_s = 1'b1;
                            if (w_at_one) begin
                                w_state_nxt = ST_ALM;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (START) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_ALM: begin
                    if (START) begin
                        w_state_nxt = ST_IDLE;
                        w_acnt_nxt  = '0;
                    end else if (EN) begin
                        if (r_acnt == c_alarm_last) begin
                            w_state_nxt = ST_IDLE;
                            w_acnt_nxt  = '0;
                        end else begin
                            w_acnt_nxt = r_acnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_acnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_acnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acnt  <= w_acnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Digit counters: seconds borrow drives the minutes down-step
    // ------------------------------------------------------------------
    sexa_updown u_sec (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (w_clr),
        .inc  (w_inc_s),
        .dec  (w_dec_s),
        .bin  (1'b0),
        .H    (SH),
        .L    (SL),
        .bout (w_sec_bout),
        .zero (w_sec_zero)
    );

    sexa_updown u_min (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (w_clr),
        .inc  (w_inc_m),
        .dec  (w_sec_bout),
        .bin  (1'b0),
        .H    (MH),
        .L    (ML),
        .bout (w_min_bout),
        .zero (w_min_zero)
    );

    // Minutes never borrow further: the FSM leaves RUN before 00:00 wraps
    logic w_unused;
    assign w_unused = w_min_bout;

    assign RUNNING = (r_state == ST_RUN);
    assign ALARM   = (r_state == ST_ALM);

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer. A reference model
//                keeps the time as plain minutes/seconds integers and the
//                mode as a small integer; directed scenarios are followed by
//                a randomized stream of button/enable pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

    localparam int ALARM_SEC = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALM = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0, START = 1'b0, CLR = 1'b0, MINUP = 1'b0, SECUP = 1'b0;
    logic [2:0] MH, SH;
    logic [3:0] ML, SL;
    logic       RUNNING, ALARM;

    int total = 0;
    int bad   = 0;

    // reference model
    int m_min = 0, m_sec = 0, m_mode = M_IDLE, m_acnt = 0;

    countdown_timer #(.ALARM_SEC(ALARM_SEC)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .CLR(CLR),
        .MINUP(MINUP), .SECUP(SECUP),
        .MH(MH), .ML(ML), .SH(SH), .SL(SL),
        .RUNNING(RUNNING), .ALARM(ALARM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".MH"}, 8'(MH), 8'(m_min / 10));
        chk({tag, ".ML"}, 8'(ML), 8'(m_min % 10));
        chk({tag, ".SH"}, 8'(SH), 8'(m_sec / 10));
        chk({tag, ".SL"}, 8'(SL), 8'(m_sec % 10));
        chk({tag, ".RUNNING"}, 8'(RUNNING), 8'(m_mode == M_RUN));
        chk({tag, ".ALARM"}, 8'(ALARM), 8'(m_mode == M_ALM));
    endtask

    // Check the displayed time against a literal MM:SS value
    task automatic chk_time(input string tag, input int mm, input int ss);
        chk({tag, ".min"}, 8'({MH, 4'(ML)} ), 8'({3'(mm / 10), 4'(mm % 10)}));
        chk({tag, ".sec"}, 8'({SH, 4'(SL)} ), 8'({3'(ss / 10), 4'(ss % 10)}));
    endtask

    task automatic model_step(input bit c, input bit s, input bit mu, input bit su, input bit e);
        int t;
        if (c) begin
            m_min = 0; m_sec = 0; m_mode = M_IDLE; m_acnt = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (s) begin
                        if (m_min * 60 + m_sec != 0) m_mode = M_RUN;
                    end else begin
                        if (mu) m_min = (m_min + 1) % 60;
                        if (su) m_sec = (m_sec + 1) % 60;
                    end
                end
                M_RUN: begin
                    if (s) m_mode = M_PAUSE;
                    else if (e) begin
                        t = m_min * 60 + m_sec - 1;
                        m_min = t / 60;
                        m_sec = t % 60;
                        if (t == 0) m_mode = M_ALM;
                    end
                end
                M_PAUSE: if (s) m_mode = M_RUN;
                default: begin
                    if (s) begin
                        m_mode = M_IDLE; m_acnt = 0;
                    end else if (e) begin
                        m_acnt++;
                        if (m_acnt == ALARM_SEC) begin
                            m_mode = M_IDLE; m_acnt = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    // One clock cycle with the given pulses; outputs checked 1 time unit
    // after the edge, then inputs are released.
    task automatic cyc(input string tag, input bit c, input bit s, input bit mu,
                       input bit su, input bit e);
        CLR = c; START = s; MINUP = mu; SECUP = su; EN = e;
        @(posedge CLK);
        model_step(c, s, mu, su, e);
        #1;
        CLR = 0; START = 0; MINUP = 0; SECUP = 0; EN = 0;
        chk_model(tag);
    endtask

    task automatic set_time(input int mm, input int ss);
        cyc("set.clr", 1, 0, 0, 0, 0);
        for (int i = 0; i < mm; i++) cyc("set.min", 0, 0, 1, 0, 0);
        for (int i = 0; i < ss; i++) cyc("set.sec", 0, 0, 0, 1, 0);
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge CLK);
        #1;
        chk_model("reset");
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_model("post_reset");

        // ---------------- setting wrap ----------------
        for (int i = 0; i < 60; i++) cyc("secup", 0, 0, 0, 1, 0);
        chk_time("secwrap", 0, 0);
        for (int i = 0; i < 61; i++) cyc("minup", 0, 0, 1, 0, 0);
        chk_time("minwrap", 1, 0);
        cyc("both", 0, 0, 1, 1, 0);
        chk_time("both", 2, 1);
        cyc("idle_en", 0, 0, 0, 0, 1);
        chk_time("idle_en", 2, 1);

        // ---------------- start at zero ----------------
        cyc("clr", 1, 0, 0, 0, 0);
        cyc("start0", 0, 1, 0, 0, 0);
        chk("start0.running", 8'(RUNNING), 8'd0);
        chk("start0.alarm", 8'(ALARM), 8'd0);

        // ---------------- borrow chain ----------------
        set_time(10, 0);
        cyc("run10", 0, 1, 0, 0, 0);
        chk("run10.running", 8'(RUNNING), 8'd1);
        cyc("borrow", 0, 0, 0, 0, 1);
        chk_time("borrow", 9, 59);
        for (int i = 0; i < 598; i++) cyc("countdown", 0, 0, 0, 0, 1);
        chk_time("at_one", 0, 1);
        cyc("to_zero", 0, 0, 0, 0, 1);
        chk_time("to_zero", 0, 0);
        chk("to_zero.alarm", 8'(ALARM), 8'd1);
        chk("to_zero.running", 8'(RUNNING), 8'd0);

        // ---------------- alarm timeout ----------------
        for (int i = 0; i < ALARM_SEC - 1; i++) cyc("alm_hold", 0, 0, 0, 0, 1);
        chk("alm_9", 8'(ALARM), 8'd1);
        cyc("alm_10", 0, 0, 0, 0, 1);
        chk("alm_10", 8'(ALARM), 8'd0);
        // ignored buttons while in alarm, then acknowledge with START
        set_time(0, 1);
        cyc("go", 0, 1, 0, 0, 0);
        cyc("hit0", 0, 0, 0, 0, 1);
        chk("hit0.alarm", 8'(ALARM), 8'd1);
        for (int i = 0; i < 3; i++) cyc("alm_en", 0, 0, 1, 1, 1);
        chk_time("alm_frozen", 0, 0);
        cyc("alm_ack", 0, 1, 0, 0, 0);
        chk("alm_ack", 8'(ALARM), 8'd0);

        // ---------------- pause and priority ----------------
        set_time(0, 7);
        cyc("go5", 0, 1, 0, 0, 0);
        cyc("dn", 0, 0, 0, 0, 1);
        cyc("dn", 0, 0, 0, 0, 1);
        chk_time("run5", 0, 5);
        cyc("pause", 0, 1, 0, 0, 1);
        chk_time("pause", 0, 5);
        chk("pause.running", 8'(RUNNING), 8'd0);
        for (int i = 0; i < 4; i++) cyc("paused_en", 0, 0, 1, 1, 1);
        chk_time("paused", 0, 5);
        cyc("resume", 0, 1, 0, 0, 1);
        chk("resume.running", 8'(RUNNING), 8'd1);
        chk_time("resume", 0, 5);
        cyc("clr_start", 1, 1, 0, 0, 1);
        chk_time("clr_start", 0, 0);
        chk("clr_start.running", 8'(RUNNING), 8'd0);

        // ---------------- reset mid-count ----------------
        set_time(2, 30);
        cyc("go230", 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("dn230", 0, 0, 0, 0, 1);
        chk_time("at227", 2, 27);
        #2;
        RST = 1'b0;
        #1;
        m_min = 0; m_sec = 0; m_mode = M_IDLE; m_acnt = 0;
        chk_model("async_rst");
        @(negedge CLK);
        RST = 1'b1;
        cyc("after_rst_en", 0, 0, 0, 0, 1);
        chk_time("after_rst", 0, 0);

        // ---------------- randomized ----------------
        for (int i = 0; i < 4000; i++) begin
            cyc("rand",
                ($urandom_range(0, 299) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_countdown_timer
`default_nettype wire
